reg_file: RTL

Parametrised multi-entry register file: `depth` words of `n` bits with one synchronous write port and two combinational read ports. It is the storage element for the datapath's architectural registers and is the multi-word generalisation of the single `n`-bit enabled register. It adds:
- address decode;
- an optional hardwired-zero entry 0;
- same-cycle write-to-read bypass;
- out-of-range address protection.

---
 rtl/reg_file.sv | 82 ++++++++
 1 files changed

// File: rtl/reg_file.sv
// reg_file: multi-entry register file with one synchronous write port and two
// combinational read ports.
//
// Parameters:
//   n        bits per word
//   depth    number of words (need not be a power of two)
//   zero_reg when 1, entry 0 always reads 0 and ignores writes
//
// Ports:
//   clk            clock, state updates on rising edge
//   reset          asynchronous active-high reset, clears every entry
//   we             write enable
//   waddr, wdata   write address / data
//   raddr1, raddr2 read addresses
//   rdata1, rdata2 combinational read data; a same-cycle write to the read
//                  address is bypassed through
module reg_file #(
  parameter int unsigned n        = 32,
  parameter int unsigned depth    = 32,
  parameter bit          zero_reg = 1'b1,
  localparam int unsigned aw      = $clog2(depth)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [aw-1:0] waddr,
  input  logic [n-1:0]  wdata,
  input  logic [aw-1:0] raddr1,
  input  logic [aw-1:0] raddr2,
  output logic [n-1:0]  rdata1,
  output logic [n-1:0]  rdata2
);

  logic [n-1:0] mem_q [depth];
  logic         write_ok;

  // Addresses at or above depth exist only when depth is not a power of two.
  function automatic logic addr_legal(input logic [aw-1:0] a);
    return 32'(a) < depth;
  endfunction

  // Entry 0 is read-only zero when zero_reg is set.
  function automatic logic addr_zero(input logic [aw-1:0] a);
    return zero_reg && (a == '0);
  endfunction

  assign write_ok = we && addr_legal(waddr) && !addr_zero(waddr);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < depth; i++) begin
        mem_q[i] <= '0;
      end
    end else if (write_ok) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Read mux shared by both ports; stored is mem_q[raddr], only meaningful
  // when the address is legal.
  function automatic logic [n-1:0] read_mux(input logic [aw-1:0] raddr,
                                            input logic [n-1:0]  stored);
    logic [n-1:0] val;
    val = '0;
    if (!reset && addr_legal(raddr) && !addr_zero(raddr)) begin
      if (write_ok && (waddr == raddr)) begin
        val = wdata;
      end else begin
        val = stored;
      end
    end
    return val;
  endfunction

  always_comb begin
    rdata1 = '0;
    rdata2 = '0;
    rdata1 = read_mux(raddr1, mem_q[raddr1]);
    rdata2 = read_mux(raddr2, mem_q[raddr2]);
  end

endmodule
